// File: rtl/pht_ctrl.sv
// -----------------------------------------------------------------------------
// pht_ctrl
// Branch predictor front-end controller sitting in front of a pattern history
// table (PHT). It serves prediction lookups with a fixed two-cycle latency and
// queues branch resolutions in a small FIFO. Queued resolutions train the PHT
// and advance a non-speculative global history register (GHR) that is used
// for gshare indexing.
//
// Arbitration: a lookup is accepted only from IDLE and only while the resolve
// queue holds fewer than DRAIN_THRESH entries. The queue head is popped in any
// IDLE cycle that does not accept a lookup. Because the PHT update strobe
// follows a pop and the PHT read strobe follows an accept, the two strobes can
// never be high in the same cycle.
//
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   lookup_valid/ready  : prediction request handshake
//   lookup_pc [7:0]     : branch address to predict
//   pred_valid          : one-cycle prediction result pulse
//   pred_taken          : predicted direction (holds while pred_valid=0)
//   pred_index [7:0]    : PHT index used (holds while pred_valid=0)
//   resolve_valid/ready : resolution push handshake
//   resolve_index [7:0] : PHT index to train
//   resolve_taken       : actual branch outcome
//   ghr_clear           : synchronous clear of the history register
//   pht_addr [7:0]      : PHT entry select (registered)
//   pht_request         : PHT read strobe (registered)
//   pht_result          : PHT update strobe (registered)
//   pht_taken           : PHT update direction (registered)
//   pht_prediction      : PHT read data, valid the cycle after pht_request
// -----------------------------------------------------------------------------
module pht_ctrl #(
   parameter int FIFO_DEPTH   = 4,
   parameter int DRAIN_THRESH = 3,
   parameter int HIST_EN      = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lookup_valid,
   output logic       lookup_ready,
   input  logic [7:0] lookup_pc,
   output logic       pred_valid,
   output logic       pred_taken,
   output logic [7:0] pred_index,
   input  logic       resolve_valid,
   output logic       resolve_ready,
   input  logic [7:0] resolve_index,
   input  logic       resolve_taken,
   input  logic       ghr_clear,
   output logic [7:0] pht_addr,
   output logic       pht_request,
   output logic       pht_result,
   output logic       pht_taken,
   input  logic       pht_prediction
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(DRAIN_THRESH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t           r_state;
   logic [7:0]       r_index;
   logic [7:0]       r_ghr;
   logic             r_pred_valid;
   logic             r_pred_taken;
   logic [7:0]       r_pred_index;
   logic [7:0]       r_pht_addr;
   logic             r_pht_request;
   logic             r_pht_result;
   logic             r_pht_taken;

   // Queue entry layout: {index[7:0], taken}
   logic [8:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_lookup_ready;
   logic             w_resolve_ready;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic [7:0]       w_index;
   logic [8:0]       w_head;

   // Pointer advance with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Handshake, arbitration and index generation.
   // The readies are gated by rst_n so they read 0 during reset yet allow an
   // accept on the very first edge after release.
   always_comb begin
      w_lookup_ready  = 1'b0;
      w_resolve_ready = 1'b0;
      w_index         = lookup_pc;
      if (rst_n && (r_state == ST_IDLE) && (r_count < CNT_THRESH)) begin
         w_lookup_ready = 1'b1;
      end else begin
         w_lookup_ready = 1'b0;
      end
      if (rst_n && (r_count < CNT_FULL)) begin
         w_resolve_ready = 1'b1;
      end else begin
         w_resolve_ready = 1'b0;
      end
      if (HIST_EN != 0) begin
         w_index = lookup_pc ^ r_ghr;
      end else begin
         w_index = lookup_pc;
      end
   end

   assign w_accept = lookup_valid && w_lookup_ready;
   assign w_push   = resolve_valid && w_resolve_ready;
   // Pops only in IDLE so a lookup in flight blocks draining.
   assign w_pop    = (r_state == ST_IDLE) && !w_accept && (r_count != '0);
   assign w_head   = r_mem[r_rd_ptr];

   // Lookup FSM and prediction outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_index      <= 8'h00;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_index <= 8'h00;
      end else begin
         r_pred_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_ISSUE;
                  r_index <= w_index;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               r_state      <= ST_CAPTURE;
               r_pred_valid <= 1'b1;
               r_pred_index <= r_index;
            end
            ST_CAPTURE: begin
               r_state      <= ST_IDLE;
               // Keep the direction so pred_taken holds once the pulse ends.
               r_pred_taken <= pht_prediction;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // PHT-side strobes, address and update direction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pht_addr    <= 8'h00;
         r_pht_request <= 1'b0;
         r_pht_result  <= 1'b0;
         r_pht_taken   <= 1'b0;
      end else if (w_accept) begin
         r_pht_addr    <= w_index;
         r_pht_request <= 1'b1;
         r_pht_result  <= 1'b0;
      end else if (w_pop) begin
         r_pht_addr    <= w_head[8:1];
         r_pht_taken   <= w_head[0];
         r_pht_request <= 1'b0;
         r_pht_result  <= 1'b1;
      end else begin
         r_pht_request <= 1'b0;
         r_pht_result  <= 1'b0;
      end
   end

   // Resolve queue storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 9'h000;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {resolve_index, resolve_taken};
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Global history: advanced only by retired (popped) outcomes; clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr <= 8'h00;
      end else if (ghr_clear) begin
         r_ghr <= 8'h00;
      end else if (w_pop && (HIST_EN != 0)) begin
         r_ghr <= {r_ghr[6:0], w_head[0]};
      end else begin
         r_ghr <= r_ghr;
      end
   end

   assign lookup_ready  = w_lookup_ready;
   assign resolve_ready = w_resolve_ready;
   assign pred_valid    = r_pred_valid;
   // The PHT read data arrives in the capture cycle itself, so the live value
   // is passed through during the pulse and the captured copy otherwise.
   assign pred_taken    = r_pred_valid ? pht_prediction : r_pred_taken;
   assign pred_index    = r_pred_index;
   assign pht_addr      = r_pht_addr;
   assign pht_request   = r_pht_request;
   assign pht_result    = r_pht_result;
   assign pht_taken     = r_pht_taken;

endmodule

// File: tb/tb_pht_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pht_ctrl
// Directed bench for pht_ctrl. Two instances share all inputs: one with gshare
// indexing (default) and one with plain pc indexing. Inputs change and outputs
// are checked on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pht_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lookup_valid;
   logic [7:0] lookup_pc;
   logic       resolve_valid;
   logic [7:0] resolve_index;
   logic       resolve_taken;
   logic       ghr_clear;
   logic       pht_prediction;

   logic       lookup_ready, pred_valid, pred_taken, resolve_ready;
   logic [7:0] pred_index, pht_addr;
   logic       pht_request, pht_result, pht_taken;

   logic       nh_lookup_ready, nh_pred_valid, nh_pred_taken, nh_resolve_ready;
   logic [7:0] nh_pred_index, nh_pht_addr;
   logic       nh_pht_request, nh_pht_result, nh_pht_taken;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pht_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_index(pred_index),
      .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
      .resolve_index(resolve_index), .resolve_taken(resolve_taken),
      .ghr_clear(ghr_clear),
      .pht_addr(pht_addr), .pht_request(pht_request), .pht_result(pht_result),
      .pht_taken(pht_taken), .pht_prediction(pht_prediction)
   );

   pht_ctrl #(.HIST_EN(0)) dut_nh (
      .clk(clk), .rst_n(rst_n),
      .lookup_valid(lookup_valid), .lookup_ready(nh_lookup_ready), .lookup_pc(lookup_pc),
      .pred_valid(nh_pred_valid), .pred_taken(nh_pred_taken), .pred_index(nh_pred_index),
      .resolve_valid(resolve_valid), .resolve_ready(nh_resolve_ready),
      .resolve_index(resolve_index), .resolve_taken(resolve_taken),
      .ghr_clear(ghr_clear),
      .pht_addr(nh_pht_addr), .pht_request(nh_pht_request), .pht_result(nh_pht_result),
      .pht_taken(nh_pht_taken), .pht_prediction(pht_prediction)
   );

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and check strobe exclusivity there.
   task automatic tick();
      @(negedge clk);
      if (rst_n) begin
         chk1("req_res_excl", pht_request & pht_result, 1'b0);
      end
   endtask

   task automatic res_chk(input string tag, input logic [7:0] addr, input logic tkn);
      chk1({tag, "_res"}, pht_result, 1'b1);
      chk8({tag, "_addr"}, pht_addr, addr);
      chk1({tag, "_tkn"}, pht_taken, tkn);
   endtask

   initial begin
      rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = 8'h00;
      resolve_valid = 1'b0; resolve_index = 8'h00; resolve_taken = 1'b0;
      ghr_clear = 1'b0; pht_prediction = 1'b0;
      tick(); tick();

      // ---- reset state ----
      chk1("rst_lookup_ready", lookup_ready, 1'b0);
      chk1("rst_resolve_ready", resolve_ready, 1'b0);
      chk1("rst_pred_valid", pred_valid, 1'b0);
      chk1("rst_pred_taken", pred_taken, 1'b0);
      chk8("rst_pred_index", pred_index, 8'h00);
      chk8("rst_pht_addr", pht_addr, 8'h00);
      chk1("rst_pht_request", pht_request, 1'b0);
      chk1("rst_pht_result", pht_result, 1'b0);
      chk1("rst_pht_taken", pht_taken, 1'b0);

      // ---- basic lookup, accepted right after release ----
      rst_n = 1'b1;
      #1 chk1("t1_ready_release", lookup_ready, 1'b1);
      lookup_valid = 1'b1; lookup_pc = 8'h5A;
      tick();
      lookup_valid = 1'b0;
      chk1("t1_req", pht_request, 1'b1);
      chk8("t1_addr", pht_addr, 8'h5A);
      chk1("t1_ready_n1", lookup_ready, 1'b0);
      chk1("t1_pv_n1", pred_valid, 1'b0);
      pht_prediction = 1'b1;
      tick();
      chk1("t1_pv", pred_valid, 1'b1);
      chk1("t1_ptaken", pred_taken, 1'b1);
      chk8("t1_pidx", pred_index, 8'h5A);
      chk1("t1_ready_n2", lookup_ready, 1'b0);
      chk1("t1_req_n2", pht_request, 1'b0);
      tick();
      chk1("t1_pv_end", pred_valid, 1'b0);
      chk1("t1_ptaken_hold", pred_taken, 1'b1);
      chk8("t1_pidx_hold", pred_index, 8'h5A);
      chk1("t1_ready_back", lookup_ready, 1'b1);
      pht_prediction = 1'b0;

      // ---- history: pops of 1,0,1 -> ghr 0x05 ----
      resolve_valid = 1'b1; resolve_index = 8'h10; resolve_taken = 1'b1;
      chk1("t2_rr", resolve_ready, 1'b1);
      tick();
      chk1("t2_nores", pht_result, 1'b0);
      resolve_index = 8'h11; resolve_taken = 1'b0;
      tick();
      res_chk("t2_pop1", 8'h10, 1'b1);
      resolve_index = 8'h12; resolve_taken = 1'b1;
      tick();
      resolve_valid = 1'b0;
      res_chk("t2_pop2", 8'h11, 1'b0);
      tick();
      res_chk("t2_pop3", 8'h12, 1'b1);
      lookup_valid = 1'b1; lookup_pc = 8'hF0;
      tick();
      lookup_valid = 1'b0;
      chk1("t2_req", pht_request, 1'b1);
      chk8("t2_addr_gshare", pht_addr, 8'hF5);
      chk8("t2_addr_plain", nh_pht_addr, 8'hF0);
      tick(); tick();

      // ---- drain priority with lookup_valid held ----
      lookup_valid = 1'b1; lookup_pc = 8'h00;
      resolve_valid = 1'b1; resolve_index = 8'h21; resolve_taken = 1'b1;
      chk1("t3_ready0", lookup_ready, 1'b1);
      tick();
      chk8("t3_addr", pht_addr, 8'h05);
      chk1("t3_ready_issue", lookup_ready, 1'b0);
      resolve_index = 8'h22; resolve_taken = 1'b0;
      tick();
      chk1("t3_ready_cap", lookup_ready, 1'b0);
      resolve_index = 8'h23; resolve_taken = 1'b1;
      tick();
      resolve_valid = 1'b0;
      chk1("t3_ready_cnt3", lookup_ready, 1'b0);
      chk1("t3_nores", pht_result, 1'b0);
      tick();
      chk1("t3_ready_cnt2", lookup_ready, 1'b1);
      res_chk("t3_pop1", 8'h21, 1'b1);
      lookup_valid = 1'b0;
      tick();
      res_chk("t3_pop2", 8'h22, 1'b0);
      tick();
      res_chk("t3_pop3", 8'h23, 1'b1);
      tick();
      chk1("t3_done", pht_result, 1'b0);

      // ---- full queue: fill behind two lookups ----
      lookup_valid = 1'b1; lookup_pc = 8'h00;
      tick();
      lookup_valid = 1'b0;
      resolve_valid = 1'b1; resolve_index = 8'h51; resolve_taken = 1'b0;
      tick();
      resolve_index = 8'h52; resolve_taken = 1'b0;
      tick();
      chk1("t4_lr_cnt2", lookup_ready, 1'b1);
      lookup_valid = 1'b1;
      resolve_index = 8'h53; resolve_taken = 1'b0;
      tick();
      lookup_valid = 1'b0;
      chk1("t4_rr_cnt3", resolve_ready, 1'b1);
      resolve_index = 8'h54; resolve_taken = 1'b1;
      tick();
      chk1("t4_rr_full", resolve_ready, 1'b0);
      resolve_index = 8'h55; resolve_taken = 1'b1;
      tick();
      chk1("t4_rr_full_idle", resolve_ready, 1'b0);
      chk1("t4_lr_full", lookup_ready, 1'b0);
      chk1("t4_nores", pht_result, 1'b0);
      tick();
      chk1("t4_rr_cnt3b", resolve_ready, 1'b1);
      chk1("t4_lr_cnt3b", lookup_ready, 1'b0);
      res_chk("t4_pop1", 8'h51, 1'b0);
      tick();
      resolve_valid = 1'b0;
      chk1("t4_rr_pushpop", resolve_ready, 1'b1);
      chk1("t4_lr_pushpop", lookup_ready, 1'b0);
      res_chk("t4_pop2", 8'h52, 1'b0);
      tick();
      chk1("t4_lr_cnt2b", lookup_ready, 1'b1);
      res_chk("t4_pop3", 8'h53, 1'b0);
      tick();
      res_chk("t4_pop4", 8'h54, 1'b1);
      tick();
      res_chk("t4_pop5", 8'h55, 1'b1);
      tick();
      chk1("t4_done", pht_result, 1'b0);

      // ---- ghr_clear beats a same-cycle shift (ghr 0xA3 here) ----
      resolve_valid = 1'b1; resolve_index = 8'h60; resolve_taken = 1'b1;
      tick();
      resolve_valid = 1'b0; ghr_clear = 1'b1;
      tick();
      ghr_clear = 1'b0;
      res_chk("t5_pop", 8'h60, 1'b1);
      lookup_valid = 1'b1; lookup_pc = 8'h3C;
      tick();
      lookup_valid = 1'b0;
      chk8("t5_addr_cleared", pht_addr, 8'h3C);
      tick(); tick();

      // ---- lookup with same-cycle clear uses pre-clear ghr (0x01) ----
      resolve_valid = 1'b1; resolve_index = 8'h61; resolve_taken = 1'b1;
      tick();
      resolve_valid = 1'b0;
      tick();
      res_chk("t5_pop2", 8'h61, 1'b1);
      lookup_valid = 1'b1; lookup_pc = 8'h3C; ghr_clear = 1'b1;
      tick();
      lookup_valid = 1'b0; ghr_clear = 1'b0;
      chk8("t5_addr_preclear", pht_addr, 8'h3D);
      tick(); tick();
      lookup_valid = 1'b1; lookup_pc = 8'h3C;
      tick();
      lookup_valid = 1'b0;
      chk8("t5_addr_postclear", pht_addr, 8'h3C);
      tick(); tick();

      // ---- reset in ISSUE with two entries queued ----
      lookup_valid = 1'b1; lookup_pc = 8'h00;
      tick();
      lookup_valid = 1'b0;
      resolve_valid = 1'b1; resolve_index = 8'h70; resolve_taken = 1'b1;
      tick();
      resolve_index = 8'h71;
      tick();
      resolve_valid = 1'b0;
      lookup_valid = 1'b1;
      tick();
      lookup_valid = 1'b0;
      chk1("t6_req", pht_request, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("t6_rst_req", pht_request, 1'b0);
      chk1("t6_rst_lr", lookup_ready, 1'b0);
      chk1("t6_rst_rr", resolve_ready, 1'b0);
      chk8("t6_rst_addr", pht_addr, 8'h00);
      tick(); tick();
      rst_n = 1'b1;
      #1 chk1("t6_lr_release", lookup_ready, 1'b1);
      tick();
      chk1("t6_pv1", pred_valid, 1'b0);
      chk1("t6_res1", pht_result, 1'b0);
      tick();
      chk1("t6_pv2", pred_valid, 1'b0);
      chk1("t6_res2", pht_result, 1'b0);
      chk1("t6_lr", lookup_ready, 1'b1);
      chk1("t6_rr", resolve_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
